// File: rtl/hwpe_engine_ctrl_mk_pkg.sv
// Shared types and default parameters for the multi-kernel HWPE engine controller.
package hwpe_engine_mk_package;

    localparam int N_KERNELS_DEF = 4;
    localparam int CNT_W_DEF     = 16;
    localparam int TO_W_DEF      = 20;

    typedef enum logic [1:0] {
        ENG_IDLE  = 2'd0,
        ENG_RUN   = 2'd1,
        ENG_DONE  = 2'd2,
        ENG_ERROR = 2'd3
    } engine_mk_state_t;

    // Default-sized views of the controller-side ctrl/flags bundles.
    typedef struct packed {
        logic                     start;
        logic                     clear;
        logic [CNT_W_DEF-1:0]     n_jobs;
        logic [N_KERNELS_DEF-1:0] lane_en;
    } ctrl_engine_mk_t;

    typedef struct packed {
        logic                 done;
        logic                 idle;
        logic                 ready;
        logic                 busy;
        logic                 error;
        logic [CNT_W_DEF-1:0] cnt;
    } flags_engine_mk_t;

endpackage

// File: rtl/hwpe_engine_ctrl_mk_if.sv
// Kernel-lane bundle between the engine controller (master) and its kernel wrappers (slave).
interface hwpe_engine_ctrl_mk_if
    import hwpe_engine_mk_package::*;
#(
    parameter int N_KERNELS = N_KERNELS_DEF
);
    logic [N_KERNELS-1:0] k_start_o;
    logic                 k_clear_o;
    logic [N_KERNELS-1:0] k_done_i;
    logic [N_KERNELS-1:0] k_ready_i;
    logic [N_KERNELS-1:0] k_idle_i;

    modport master (
        output k_start_o, k_clear_o,
        input  k_done_i, k_ready_i, k_idle_i
    );

    modport slave (
        input  k_start_o, k_clear_o,
        output k_done_i, k_ready_i, k_idle_i
    );
endinterface

// File: rtl/hwpe_engine_ctrl_mk_rr_arb.sv
// N-way round-robin arbiter: one-hot grant, search starts at the pointer,
// pointer moves one past the granted lane when the grant is taken.
module hwpe_engine_rr_arb
    import hwpe_engine_mk_package::*;
#(
    parameter int N = N_KERNELS_DEF
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear,
    input  logic         advance,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_nxt;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        grant   = '0;
        found   = 1'b0;
        ptr_nxt = ptr_q;
        idx     = '0;
        for (int off = 0; off < N; off++) begin
            idx = PW'((int'(ptr_q) + off) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
                ptr_nxt    = PW'((int'(idx) + 1) % N);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (clear) begin
            ptr_q <= '0;
        end else if (advance && found) begin
            ptr_q <= ptr_nxt;
        end
    end

endmodule

// File: rtl/hwpe_engine_ctrl_mk.sv
// Multi-kernel engine controller: dispatches a batch of jobs round-robin over enabled
// kernel lanes, retires completions, counts them and guards the batch with a watchdog.
//
//   state | meaning
//   IDLE  | waiting for start_i with a non-empty lane mask
//   RUN   | dispatching jobs and retiring completions
//   DONE  | batch complete, done_o follows one cycle later
//   ERROR | watchdog expired, left only through clear_i
module hwpe_engine_ctrl_mk
    import hwpe_engine_mk_package::*;
#(
    parameter int N_KERNELS = N_KERNELS_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int TO_W      = TO_W_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  test_mode_i,
    input  logic                  start_i,
    input  logic                  clear_i,
    input  logic [CNT_W-1:0]      n_jobs_i,
    input  logic [N_KERNELS-1:0]  lane_en_i,
    hwpe_engine_ctrl_mk_if.master kern,
    output logic                  done_o,
    output logic                  idle_o,
    output logic                  ready_o,
    output logic                  busy_o,
    output logic                  error_o,
    output logic [CNT_W-1:0]      cnt_o
);
    localparam logic [1:0] ST_IDLE  = ENG_IDLE;
    localparam logic [1:0] ST_RUN   = ENG_RUN;
    localparam logic [1:0] ST_DONE  = ENG_DONE;
    localparam logic [1:0] ST_ERROR = ENG_ERROR;

    function automatic logic [CNT_W-1:0] popcnt(input logic [N_KERNELS-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_KERNELS; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     n_jobs_q, issued_q, completed_q, cnt_q, n_ret;
    logic [N_KERNELS-1:0] lane_en_q, lane_busy_q, req, grant, start_vec, done_hit;
    logic [TO_W-1:0]      wd_q;
    logic                 done_q, ready_q, error_q, k_clear_q;
    logic                 in_run, dispatch, start_ok, all_done, wd_count, wd_expire;
    logic                 unused_test_mode;

    assign unused_test_mode = test_mode_i;

    assign in_run    = (state_q == ST_RUN);
    assign start_ok  = (state_q == ST_IDLE) && start_i && (|lane_en_i);
    assign dispatch  = in_run && (issued_q < n_jobs_q) && !clear_i;
    assign req       = lane_en_q & kern.k_ready_i & ~lane_busy_q;
    assign start_vec = dispatch ? grant : '0;

    // Only dones on lanes that actually hold a job count; strays are dropped.
    assign done_hit  = kern.k_done_i & lane_busy_q & {N_KERNELS{in_run}};
    assign n_ret     = popcnt(done_hit);
    assign all_done  = (completed_q + n_ret) == n_jobs_q;
    assign wd_count  = in_run && (n_ret == '0) && (|lane_busy_q);
    assign wd_expire = wd_count && (wd_q == TO_W'(1));

    hwpe_engine_rr_arb #(
        .N (N_KERNELS)
    ) i_rr_arb (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear   (clear_i),
        .advance (dispatch),
        .req     (req),
        .grant   (grant)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) state_d = (n_jobs_i == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (all_done)       state_d = ST_DONE;
                else if (wd_expire) state_d = ST_ERROR;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = state_q;
        endcase
        if (clear_i) state_d = ST_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            n_jobs_q    <= '0;
            lane_en_q   <= '0;
            issued_q    <= '0;
            completed_q <= '0;
            cnt_q       <= '0;
            lane_busy_q <= '0;
            wd_q        <= '1;
            done_q      <= 1'b0;
            ready_q     <= 1'b0;
            error_q     <= 1'b0;
            k_clear_q   <= 1'b0;
        end else begin
            ready_q <= (state_q == ST_IDLE);
            state_q <= state_d;
            if (clear_i) begin
                n_jobs_q    <= '0;
                lane_en_q   <= '0;
                issued_q    <= '0;
                completed_q <= '0;
                cnt_q       <= '0;
                lane_busy_q <= '0;
                wd_q        <= '1;
                done_q      <= 1'b0;
                error_q     <= 1'b0;
                k_clear_q   <= 1'b1;
            end else begin
                k_clear_q   <= 1'b0;
                done_q      <= (state_q == ST_DONE);
                cnt_q       <= cnt_q + n_ret;
                // A done and a fresh start on one lane in one cycle leave it busy.
                lane_busy_q <= (lane_busy_q & ~done_hit) | start_vec;
                if (start_ok) begin
                    n_jobs_q    <= n_jobs_i;
                    lane_en_q   <= lane_en_i;
                    issued_q    <= '0;
                    completed_q <= '0;
                end else begin
                    if (|start_vec) issued_q <= issued_q + CNT_W'(1);
                    completed_q <= completed_q + n_ret;
                end
                if (!in_run || (n_ret != '0)) wd_q <= '1;
                else if (wd_count)            wd_q <= wd_q - TO_W'(1);
                if (wd_expire) error_q <= 1'b1;
            end
        end
    end

    assign kern.k_start_o = start_vec;
    assign kern.k_clear_o = k_clear_q;
    assign done_o  = done_q;
    assign ready_o = ready_q;
    assign busy_o  = in_run;
    assign error_o = error_q;
    assign cnt_o   = cnt_q;
    assign idle_o  = ready_q && (state_q == ST_IDLE) && ~|(lane_en_q & ~kern.k_idle_i);

endmodule

// File: tb/tb_hwpe_engine_ctrl_mk.sv
// Directed bench for hwpe_engine_ctrl_mk: batch vectors plus watchdog and mid-batch clear sequences.
module tb_hwpe_engine_ctrl_mk;

    logic        clk_i, rst_ni, test_mode_i, start_i, clear_i;
    logic [15:0] n_jobs_i;
    logic [3:0]  lane_en_i;
    logic        done_o, idle_o, ready_o, busy_o, error_o;
    logic [15:0] cnt_o;

    hwpe_engine_ctrl_mk_if #(.N_KERNELS(4)) kif ();

    hwpe_engine_ctrl_mk #(
        .N_KERNELS (4),
        .CNT_W     (16),
        .TO_W      (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .test_mode_i (test_mode_i),
        .start_i     (start_i),
        .clear_i     (clear_i),
        .n_jobs_i    (n_jobs_i),
        .lane_en_i   (lane_en_i),
        .kern        (kif),
        .done_o      (done_o),
        .idle_o      (idle_o),
        .ready_o     (ready_o),
        .busy_o      (busy_o),
        .error_o     (error_o),
        .cnt_o       (cnt_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    typedef struct packed {
        logic [15:0] n_jobs;
        logic [3:0]  lane_en;
        logic [15:0] lat;        // per-lane kernel latency, one nibble per lane
        logic [7:0]  exp_nstart;
        logic [31:0] exp_order;  // lane of the k-th start in nibble k
        logic [7:0]  exp_dcyc;   // cycle of the done_o pulse after start, 0 = none
        logic [15:0] exp_cnt;
        logic [7:0]  exp_maxd;   // largest single-cycle cnt_o step
    } vec_t;

    vec_t        vecs[5];
    int          n_chk, n_fail;
    int          kt[4];
    logic [15:0] lat_cur;
    int          nstart, ndone, dcyc, maxd, t_cur;
    logic [31:0] order;
    logic [15:0] prev_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp_v);
        end
    endtask

    // One cycle: kernel model drives done/idle at negedge, outputs sampled 1 time unit later.
    task automatic tick();
        logic [3:0]  kd, ki, st;
        logic [15:0] dlt;
        @(negedge clk_i);
        for (int i = 0; i < 4; i++) begin
            kd[i] = 1'b0;
            if (kt[i] > 0) begin
                kt[i]--;
                if (kt[i] == 0) kd[i] = 1'b1;
            end
            ki[i] = (kt[i] == 0);
        end
        kif.k_done_i = kd;
        kif.k_idle_i = ki;
        #1;
        st = kif.k_start_o;
        if (st != 4'b0) begin
            chk("start_onehot", 32'($onehot(st)), 32'd1);
            for (int i = 0; i < 4; i++) begin
                if (st[i]) begin
                    if (nstart < 8) order[4*nstart +: 4] = 4'(i);
                    kt[i] = (lat_cur[4*i +: 4] == 4'hF) ? 1000 : int'(lat_cur[4*i +: 4]);
                end
            end
            nstart++;
        end
        if (done_o) begin
            ndone++;
            dcyc = t_cur;
        end
        dlt = cnt_o - prev_cnt;
        if (int'(dlt) > maxd) maxd = int'(dlt);
        prev_cnt = cnt_o;
    endtask

    task automatic run_batch(input vec_t v, input int idx);
        logic exp_run;
        exp_run   = (v.lane_en != 4'b0) && (v.n_jobs != 16'd0);
        lat_cur   = v.lat;
        n_jobs_i  = v.n_jobs;
        lane_en_i = v.lane_en;
        start_i   = 1'b1;
        nstart = 0; ndone = 0; dcyc = 0; maxd = 0; order = '0; prev_cnt = cnt_o;
        for (int t = 1; t <= 24; t++) begin
            t_cur = t;
            tick();
            if (t == 1) begin
                start_i = 1'b0;
                chk($sformatf("v%0d_busy_t1", idx), 32'(busy_o), 32'(exp_run));
            end
            if (t == 2) chk($sformatf("v%0d_ready_t2", idx), 32'(ready_o), 32'(v.lane_en == 4'b0));
        end
        chk($sformatf("v%0d_nstart", idx), nstart, 32'(v.exp_nstart));
        chk($sformatf("v%0d_order", idx), order, v.exp_order);
        chk($sformatf("v%0d_ndone", idx), ndone, 32'(v.exp_dcyc != 8'd0));
        chk($sformatf("v%0d_done_cyc", idx), dcyc, 32'(v.exp_dcyc));
        chk($sformatf("v%0d_cnt", idx), 32'(cnt_o), 32'(v.exp_cnt));
        chk($sformatf("v%0d_max_step", idx), maxd, 32'(v.exp_maxd));
        chk($sformatf("v%0d_ready_end", idx), 32'(ready_o), 32'd1);
        chk($sformatf("v%0d_idle_end", idx), 32'(idle_o), 32'd1);
    endtask

    initial begin
        int ns0;
        n_chk = 0; n_fail = 0; t_cur = 0;
        nstart = 0; ndone = 0; dcyc = 0; maxd = 0; order = '0; prev_cnt = '0;
        for (int i = 0; i < 4; i++) kt[i] = 0;
        lat_cur = 16'h3333;
        rst_ni = 1'b0; test_mode_i = 1'b0; start_i = 1'b0; clear_i = 1'b0;
        n_jobs_i = '0; lane_en_i = '0;
        kif.k_done_i = '0; kif.k_ready_i = '1; kif.k_idle_i = '1;

        vecs[0] = '{16'd8, 4'hF, 16'h3333, 8'd8, 32'h3210_3210, 8'd13, 16'd8,  8'd1};
        vecs[1] = '{16'd5, 4'h5, 16'h3333, 8'd5, 32'h0000_2020, 8'd14, 16'd13, 8'd1};
        vecs[2] = '{16'd4, 4'hF, 16'h4563, 8'd4, 32'h0000_0321, 8'd9,  16'd17, 8'd4};
        vecs[3] = '{16'd0, 4'hF, 16'h3333, 8'd0, 32'h0,         8'd2,  16'd17, 8'd0};
        vecs[4] = '{16'd3, 4'h0, 16'h3333, 8'd0, 32'h0,         8'd0,  16'd17, 8'd0};

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        #1;
        chk("rst_flags", {27'd0, done_o, idle_o, ready_o, busy_o, error_o}, 32'd0);
        chk("rst_kern", {27'd0, kif.k_clear_o, kif.k_start_o}, 32'd0);
        chk("rst_cnt", 32'(cnt_o), 32'd0);
        rst_ni = 1'b1;
        tick();
        chk("post_rst_ready", 32'(ready_o), 32'd1);
        chk("post_rst_idle", 32'(idle_o), 32'd1);

        for (int v = 0; v < 5; v++) run_batch(vecs[v], v);

        // Watchdog: lane 0 never answers, error after 15 counted cycles.
        lat_cur = 16'h000F; n_jobs_i = 16'd1; lane_en_i = 4'b0001; start_i = 1'b1;
        nstart = 0; ndone = 0;
        for (int t = 1; t <= 17; t++) begin
            t_cur = t;
            tick();
            if (t == 1) start_i = 1'b0;
            if (t == 16) chk("wd_err_t16", 32'(error_o), 32'd0);
            if (t == 17) begin
                chk("wd_err_t17", 32'(error_o), 32'd1);
                chk("wd_busy_t17", 32'(busy_o), 32'd0);
            end
        end
        chk("wd_nstart", nstart, 32'd1);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        chk("err_start_ignored", nstart, 32'd1);
        chk("err_sticky", 32'(error_o), 32'd1);
        chk("err_ready", 32'(ready_o), 32'd0);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        kt[0] = 0;
        chk("clr_kclear", 32'(kif.k_clear_o), 32'd1);
        chk("clr_error", 32'(error_o), 32'd0);
        chk("clr_cnt", 32'(cnt_o), 32'd0);
        chk("clr_busy", 32'(busy_o), 32'd0);
        tick();
        chk("clr_kclear_1cyc", 32'(kif.k_clear_o), 32'd0);
        chk("clr_ready", 32'(ready_o), 32'd1);
        chk("clr_idle", 32'(idle_o), 32'd1);

        // Clear mid-batch once 3 of 8 jobs have completed.
        lat_cur = 16'h3333; n_jobs_i = 16'd8; lane_en_i = 4'hF; start_i = 1'b1;
        nstart = 0; ndone = 0;
        for (int t = 1; t <= 7; t++) begin
            t_cur = t;
            tick();
            if (t == 1) start_i = 1'b0;
        end
        chk("mid_cnt3", 32'(cnt_o), 32'd3);
        chk("mid_nstart", nstart, 32'd7);
        ns0 = nstart;
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("mid_kclear", 32'(kif.k_clear_o), 32'd1);
        chk("mid_busy", 32'(busy_o), 32'd0);
        chk("mid_cnt_clr", 32'(cnt_o), 32'd0);
        for (int t = 9; t <= 24; t++) begin
            t_cur = t;
            tick();
            if (t == 9) chk("mid_kclear_1cyc", 32'(kif.k_clear_o), 32'd0);
        end
        chk("mid_no_starts", nstart, ns0);
        chk("mid_no_done", ndone, 32'd0);
        chk("mid_late_done_ignored", 32'(cnt_o), 32'd0);
        chk("mid_error", 32'(error_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

endmodule
